binary_mul_pipe_param: RTL and testbench

- Parametrised, fully pipelined array multiplier. Next generation of the fixed-width pipelined array multipliers.
- Generalises operand width and adds a per-transaction signed/unsigned mode.
- Adds a valid pipeline with a global stall (`en`), and carries operands down the pipe, so a new product can be issued every cycle.
- Sits in the arithmetic datapath between operand registers and the consumer of the 2*WIDTH product.

---
 rtl/binary_mul_pipe_param.sv | 124 ++++++++++++
 tb/tb_binary_mul_pipe_param.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/binary_mul_pipe_param.sv
// ============================================================================
// binary_mul_pipe_param : WIDTH x WIDTH pipelined carry-save array multiplier,
// signed/unsigned per sample, stall via en.
// Optional accumulator: define BINARY_MUL_ACC_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module binary_mul_pipe_param #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               valid_in,
  input  logic               tc,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef BINARY_MUL_ACC_EN
  input  logic               acc_clr,
  output logic [2*WIDTH+3:0] ACC,
`endif
  output logic               valid_out,
  output logic               tc_out,
  output logic [2*WIDTH-1:0] P
);

  localparam int LAT = WIDTH + 1;
  localparam int PW  = 2 * WIDTH;

  // Operand extended to product width; sign extension only in signed mode.
  function automatic logic [PW-1:0] ext_op(input logic [WIDTH-1:0] a, input logic s);
    return {{WIDTH{s & a[WIDTH-1]}}, a};
  endfunction

  logic [PW-1:0]    sum_r   [WIDTH];
  logic [PW-1:0]    carry_r [WIDTH];
  logic [WIDTH-1:0] a_r     [WIDTH];
  logic [WIDTH-1:0] b_r     [WIDTH];
  logic             tc_r    [WIDTH];
  logic             vld_r   [WIDTH];
`ifdef BINARY_MUL_ACC_EN
  logic             clr_r   [WIDTH];
`endif

  logic [PW-1:0]    sum_n   [1:WIDTH-1];
  logic [PW-1:0]    carry_n [1:WIDTH-1];
  logic [PW-1:0]    p_next;

  // Row j adds B[j]*A<<j; in signed mode the top row carries negative weight,
  // so it is inverted and the +1 is injected into the free carry LSB.
  for (genvar j = 1; j < LAT - 1; j++) begin : g_row
    logic [PW-1:0] row;
    logic [PW-1:0] pp;
    logic [PW-1:0] maj;
    logic          neg;
    assign neg          = (j == WIDTH - 1) ? tc_r[j-1] : 1'b0;
    assign row          = b_r[j-1][j] ? (ext_op(a_r[j-1], tc_r[j-1]) << j) : '0;
    assign pp           = neg ? ~row : row;
    assign maj          = (sum_r[j-1] & carry_r[j-1]) | (sum_r[j-1] & pp) | (carry_r[j-1] & pp);
    assign sum_n[j]     = sum_r[j-1] ^ carry_r[j-1] ^ pp;
    assign carry_n[j]   = {maj[PW-2:0], neg};
  end

  assign p_next = sum_r[WIDTH-1] + carry_r[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < WIDTH; j++) begin
        sum_r[j]   <= '0;
        carry_r[j] <= '0;
        a_r[j]     <= '0;
        b_r[j]     <= '0;
        tc_r[j]    <= 1'b0;
        vld_r[j]   <= 1'b0;
`ifdef BINARY_MUL_ACC_EN
        clr_r[j]   <= 1'b0;
`endif
      end
      P         <= '0;
      valid_out <= 1'b0;
      tc_out    <= 1'b0;
    end else if (en) begin
      sum_r[0]   <= B[0] ? ext_op(A, tc) : '0;
      carry_r[0] <= '0;
      a_r[0]     <= A;
      b_r[0]     <= B;
      tc_r[0]    <= tc;
      vld_r[0]   <= valid_in;
`ifdef BINARY_MUL_ACC_EN
      clr_r[0]   <= acc_clr;
`endif
      for (int j = 1; j < WIDTH; j++) begin
        sum_r[j]   <= sum_n[j];
        carry_r[j] <= carry_n[j];
        a_r[j]     <= a_r[j-1];
        b_r[j]     <= b_r[j-1];
        tc_r[j]    <= tc_r[j-1];
        vld_r[j]   <= vld_r[j-1];
`ifdef BINARY_MUL_ACC_EN
        clr_r[j]   <= clr_r[j-1];
`endif
      end
      P         <= p_next;
      valid_out <= vld_r[WIDTH-1];
      tc_out    <= tc_r[WIDTH-1];
    end
  end

`ifdef BINARY_MUL_ACC_EN
  logic [PW+3:0] p_ext;
  assign p_ext = {{4{tc_r[WIDTH-1] & p_next[PW-1]}}, p_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      ACC <= '0;
    end else if (en && vld_r[WIDTH-1]) begin
      ACC <= (clr_r[WIDTH-1] ? '0 : ACC) + p_ext;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_binary_mul_pipe_param.sv
// Randomized + directed bench for binary_mul_pipe_param with an arithmetic
// reference model and an in-order expected-result queue.
`default_nettype none

module tb_binary_mul_pipe_param;

  localparam int W   = 5;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst, en, valid_in, tc;
  logic [W-1:0]   A, B;
  logic           valid_out, tc_out;
  logic [2*W-1:0] P;
`ifdef BINARY_MUL_ACC_EN
  logic           acc_clr;
  logic [2*W+3:0] ACC;
  logic [2*W+3:0] exp_acc;
`endif

  binary_mul_pipe_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .tc(tc), .A(A), .B(B),
`ifdef BINARY_MUL_ACC_EN
    .acc_clr(acc_clr), .ACC(ACC),
`endif
    .valid_out(valid_out), .tc_out(tc_out), .P(P)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             issue;
    logic           t;
    logic [2*W-1:0] p;
    logic           clr;
  } exp_t;

  exp_t           q[$];
  int             checks = 0;
  int             errors = 0;
  int             ecnt   = 0;
  logic [2*W-1:0] prev_p;
  logic           prev_v, prev_tc;

  function automatic logic [2*W-1:0] ref_prod(input logic t, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, p;
    x = t ? longint'($signed(a)) : longint'(a);
    y = t ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic vi, input logic t,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic r, input logic clr);
    exp_t it;
    logic due;
    prev_p  = P;
    prev_v  = valid_out;
    prev_tc = tc_out;
    en = e; valid_in = vi; tc = t; A = a; B = b; rst = r;
`ifdef BINARY_MUL_ACC_EN
    acc_clr = clr;
`endif
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_P", 64'(P), 64'd0);
      chk("rst_tc_out", 64'(tc_out), 64'd0);
`ifdef BINARY_MUL_ACC_EN
      exp_acc = '0;
      chk("rst_ACC", 64'(ACC), 64'd0);
`endif
    end else if (!e) begin
      chk("stall_P", 64'(P), 64'(prev_p));
      chk("stall_valid_out", 64'(valid_out), 64'(prev_v));
      chk("stall_tc_out", 64'(tc_out), 64'(prev_tc));
    end else begin
      ecnt++;
      if (vi) q.push_back('{issue: ecnt, t: t, p: ref_prod(t, a, b), clr: clr});
      due = (q.size() > 0) && (ecnt - q[0].issue == LAT - 1);
      chk("valid_out", 64'(valid_out), 64'(due));
      if (due) begin
        it = q.pop_front();
        chk("P", 64'(P), 64'(it.p));
        chk("tc_out", 64'(tc_out), 64'(it.t));
`ifdef BINARY_MUL_ACC_EN
        if (it.clr) exp_acc = '0;
        exp_acc = exp_acc + {{4{it.t & it.p[2*W-1]}}, it.p};
        chk("ACC", 64'(ACC), 64'(exp_acc));
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
`ifdef BINARY_MUL_ACC_EN
    exp_acc = '0;
`endif
    // Reset state
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, '1, '1, 1'b1, 1'b0);

    // Single unsigned max*max issue, then wait for it
    step(1'b1, 1'b1, 1'b0, '1, '1, 1'b0, 1'b1);
    idle(LAT + 1);

    // Back-to-back signed boundary operands
    step(1'b1, 1'b1, 1'b1, W'(1 << (W-1)), W'(1 << (W-1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, '1, W'(1), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, W'((1 << (W-1)) - 1), W'(1 << (W-1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, '0, W'(-7), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '1, W'(1 << (W-1)), 1'b0, 1'b0);
    idle(LAT + 1);

    // Unsigned stream k*3 with a 3-cycle stall mid-stream (valid_in high while stalled)
    for (int k = 1; k <= 8; k++) begin
      if (k == 5)
        for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 1'b0, W'(20), W'(3), 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, W'(k), W'(3), 1'b0, 1'b0);
    end
    idle(LAT + 1);

    // Mid-operation reset drops in-flight samples
    step(1'b1, 1'b1, 1'b0, W'(3), W'(5), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, W'(7), W'(9), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, W'(2), W'(2), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(LAT + 1);
    step(1'b1, 1'b1, 1'b1, W'(6), W'(-3), 1'b0, 1'b1);
    idle(LAT + 1);

    // Randomized traffic with stalls, bubbles and rare resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           W'($urandom), W'($urandom), ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 15) == 0));
    end
    idle(LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
